// File: rtl/prog_load_capture.sv
// Streams a program image into the core's oob write port, pulses core reset,
// runs the core for a fixed budget and captures outen-qualified output words.
module prog_load_capture #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int LOAD_DEPTH = 256,
    parameter int OUT_W      = 8,
    parameter int OUT_IN_W   = 16,
    parameter int CAP_DEPTH  = 32,
    parameter int RST_CYCLES = 1,
    parameter int RUN_CYCLES = 40
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           ld_valid,
    input  logic [DATA_W-1:0]              ld_data,
    input  logic                           ld_last,
    output logic                           ld_ready,
    output logic                           oob_mem_wen,
    output logic [ADDR_W-1:0]              oob_write_addr,
    output logic [DATA_W-1:0]              oob_write_data,
    output logic                           comp_rst,
    input  logic [OUT_IN_W-1:0]            out,
    input  logic                           outen,
    input  logic [$clog2(CAP_DEPTH)-1:0]   rd_addr,
    output logic [OUT_W-1:0]               rd_data,
    output logic [$clog2(CAP_DEPTH+1)-1:0] cap_count,
    output logic                           cap_overflow,
    output logic                           busy,
    output logic                           done
);
    // state | meaning
    // IDLE  | after reset, waiting for start
    // LOAD  | accepting program words, writing them to the core
    // RESET | core held in reset for RST_CYCLES
    // RUN   | core running, outputs captured
    // DONE  | run finished or aborted, buffer readable
    localparam int CIDX_W = $clog2(CAP_DEPTH);
    localparam int CCNT_W = $clog2(CAP_DEPTH + 1);
    localparam int RUN_W  = $clog2(RUN_CYCLES + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RESET, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                oob_wen_q, oob_wen_d;
    logic [ADDR_W-1:0]   oob_addr_q, oob_addr_d;
    logic [DATA_W-1:0]   oob_data_q, oob_data_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [CCNT_W-1:0]   cap_count_q, cap_count_d;
    logic                cap_overflow_q, cap_overflow_d;
    logic [OUT_W-1:0]    rd_data_q, rd_data_d;
    logic                ld_hs;
    logic                cap_we;
    logic [CIDX_W-1:0]   cap_waddr;
    logic [OUT_W-1:0]    cap_mem [CAP_DEPTH];
    logic                unused_out_hi;

    assign unused_out_hi = ^out;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        oob_wen_d      = 1'b0;
        oob_addr_d     = oob_addr_q;
        oob_data_d     = oob_data_q;
        rst_cnt_d      = rst_cnt_q;
        run_cnt_d      = run_cnt_q;
        cap_count_d    = cap_count_q;
        cap_overflow_d = cap_overflow_q;
        cap_we         = 1'b0;
        cap_waddr      = cap_count_q[CIDX_W-1:0];
        ld_hs          = ld_valid && (state_q == S_LOAD);

        if (ld_hs) begin
            oob_wen_d  = 1'b1;
            oob_addr_d = addr_q;
            oob_data_d = ld_data;
            addr_d     = addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_LOAD;
                    addr_d         = '0;
                    cap_count_d    = '0;
                    cap_overflow_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (ld_hs && (ld_last || addr_q == ADDR_W'(LOAD_DEPTH - 1))) begin
                    state_d   = S_RESET;
                    rst_cnt_d = RST_W'(RST_CYCLES - 1);
                end
            end
            S_RESET: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (rst_cnt_q == '0) begin
                    state_d   = S_RUN;
                    run_cnt_d = RUN_W'(RUN_CYCLES - 1);
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_W'(1);
                end
            end
            S_RUN: begin
                // Capture is independent of abort/terminal count in the same cycle.
                if (outen) begin
                    if (cap_count_q < CCNT_W'(CAP_DEPTH)) begin
                        cap_we      = 1'b1;
                        cap_count_d = cap_count_q + CCNT_W'(1);
                    end else begin
                        cap_overflow_d = 1'b1;
                    end
                end
                if (abort || run_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    run_cnt_d = run_cnt_q - RUN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_data_d = (CCNT_W'(rd_addr) < cap_count_q) ? cap_mem[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            oob_wen_q      <= 1'b0;
            oob_addr_q     <= '0;
            oob_data_q     <= '0;
            rst_cnt_q      <= '0;
            run_cnt_q      <= '0;
            cap_count_q    <= '0;
            cap_overflow_q <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            oob_wen_q      <= oob_wen_d;
            oob_addr_q     <= oob_addr_d;
            oob_data_q     <= oob_data_d;
            rst_cnt_q      <= rst_cnt_d;
            run_cnt_q      <= run_cnt_d;
            cap_count_q    <= cap_count_d;
            cap_overflow_q <= cap_overflow_d;
            rd_data_q      <= rd_data_d;
        end
    end

    // Buffer contents are not cleared; readback masks entries beyond cap_count.
    always_ff @(posedge clk) begin
        if (cap_we && !rst) begin
            cap_mem[cap_waddr] <= out[OUT_W-1:0];
        end
    end

    assign ld_ready       = (state_q == S_LOAD);
    assign oob_mem_wen    = oob_wen_q;
    assign oob_write_addr = oob_addr_q;
    assign oob_write_data = oob_data_q;
    assign comp_rst       = (state_q != S_RUN);
    assign rd_data        = rd_data_q;
    assign cap_count      = cap_count_q;
    assign cap_overflow   = cap_overflow_q;
    assign busy           = (state_q == S_LOAD) || (state_q == S_RESET) || (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
endmodule

// File: tb/tb_prog_load_capture.sv
// Directed bench for prog_load_capture: table-driven load sequence plus
// hand-written run, overflow, abort and reset corner cases.
module tb_prog_load_capture;
    logic        clk = 1'b0;
    logic        rst, start, abort, ld_valid, ld_last, outen;
    logic [15:0] ld_data, out_w;
    logic        ld_ready, oob_mem_wen, comp_rst, cap_overflow, busy, done;
    logic [15:0] oob_write_addr, oob_write_data;
    logic [1:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [2:0]  cap_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_load_capture #(
        .DATA_W(16), .ADDR_W(16), .LOAD_DEPTH(8), .OUT_W(8), .OUT_IN_W(16),
        .CAP_DEPTH(4), .RST_CYCLES(1), .RUN_CYCLES(40)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .oob_mem_wen(oob_mem_wen), .oob_write_addr(oob_write_addr),
        .oob_write_data(oob_write_data), .comp_rst(comp_rst),
        .out(out_w), .outen(outen), .rd_addr(rd_addr), .rd_data(rd_data),
        .cap_count(cap_count), .cap_overflow(cap_overflow), .busy(busy), .done(done)
    );

    typedef struct {
        logic        start;
        logic        ld_valid;
        logic [15:0] ld_data;
        logic        ld_last;
        logic        e_ready;
        logic        e_wen;
        logic [15:0] e_addr;
        logic [15:0] e_data;
        logic        e_crst;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts RUN cycles (comp_rst low) and drives outen from mask; out values
    // step by 'step' per pulse starting at 'base'.
    task automatic run_phase(input logic [63:0] mask, input logic [15:0] base,
                             input logic [15:0] step, output int k);
        int  p;
        bit  finished;
        k = 0;
        p = 0;
        finished = 0;
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            if (!comp_rst) begin
                if (k == 0) chk("wen_low_in_run", oob_mem_wen, 0);
                outen = (k < 64) ? mask[k] : 1'b0;
                out_w = base + step * 16'(p);
                if (outen) p++;
                k++;
            end else begin
                outen = 1'b0;
                if (k > 0) begin
                    finished = 1;
                    break;
                end
            end
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: run did not finish, cycles=%0d", k);
        end
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk($sformatf("rd_data[%0d]", a), rd_data, exp);
    endtask

    initial begin
        int          k, nw;
        logic [63:0] mask;
        bit          seen;

        rst = 1'b1; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_data = '0;
        ld_last = 1'b0; outen = 1'b0; out_w = '0; rd_addr = '0;

        // Expected outputs of a row are checked before that row's inputs are driven.
        tbl[0] = '{1, 0, 16'h0000, 0,  0, 0, 16'h0, 16'h0000, 1, 0, 0};
        tbl[1] = '{0, 1, 16'h1111, 0,  1, 0, 16'h0, 16'h0000, 1, 1, 0};
        tbl[2] = '{0, 1, 16'h2222, 0,  1, 1, 16'h0, 16'h1111, 1, 1, 0};
        tbl[3] = '{0, 1, 16'h3333, 0,  1, 1, 16'h1, 16'h2222, 1, 1, 0};
        tbl[4] = '{0, 1, 16'h4444, 1,  1, 1, 16'h2, 16'h3333, 1, 1, 0};
        tbl[5] = '{0, 0, 16'h0000, 0,  0, 1, 16'h3, 16'h4444, 1, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_oob", {oob_mem_wen, oob_write_addr, oob_write_data}, 0);
        chk("rst_comp_rst", comp_rst, 1);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cap", {cap_count, cap_overflow}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t%0d_ld_ready", i), ld_ready, tbl[i].e_ready);
            chk($sformatf("t%0d_wen", i), oob_mem_wen, tbl[i].e_wen);
            if (tbl[i].e_wen) begin
                chk($sformatf("t%0d_addr", i), oob_write_addr, tbl[i].e_addr);
                chk($sformatf("t%0d_data", i), oob_write_data, tbl[i].e_data);
            end
            chk($sformatf("t%0d_comp_rst", i), comp_rst, tbl[i].e_crst);
            chk($sformatf("t%0d_busy_done", i), {busy, done}, {tbl[i].e_busy, tbl[i].e_done});
            start    = tbl[i].start;
            ld_valid = tbl[i].ld_valid;
            ld_data  = tbl[i].ld_data;
            ld_last  = tbl[i].ld_last;
        end

        // Run with outen on RUN cycles 3, 7, 9.
        mask = '0;
        mask[3] = 1'b1; mask[7] = 1'b1; mask[9] = 1'b1;
        run_phase(mask, 16'h00A1, 16'h0011, k);
        chk("run_cycles", k, 40);
        chk("done_after_run", {done, busy, comp_rst}, 3'b101);
        chk("cap_count_3", cap_count, 3);
        chk("no_overflow", cap_overflow, 0);
        rd_check(2'd0, 8'hA1);
        rd_check(2'd1, 8'hB2);
        rd_check(2'd2, 8'hC3);
        rd_check(2'd3, 8'h00);

        // LOAD_DEPTH limit: 10 words offered, no ld_last.
        start_pulse();
        chk("restart_cap_clear", cap_count, 0);
        chk("restart_ready", {ld_ready, busy}, 2'b11);
        ld_valid = 1'b1;
        ld_data  = 16'h0100;
        nw = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (oob_mem_wen) begin
                chk($sformatf("depth_addr%0d", nw), oob_write_addr, nw);
                chk($sformatf("depth_data%0d", nw), oob_write_data, 16'h0100 + 16'(nw));
                nw++;
            end
            ld_valid = (i + 1 < 10);
            ld_data  = 16'h0100 + 16'(i + 1);
        end
        ld_valid = 1'b0;
        chk("depth_writes", nw, 8);
        chk("depth_ready_low", ld_ready, 0);
        run_phase('0, 16'h0, 16'h0, k);
        chk("depth_done", done, 1);

        // Capture overflow: 6 pulses into a 4-entry buffer.
        start_pulse();
        ld_valid = 1'b1; ld_data = 16'h5A5A; ld_last = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("ovf_load_wen", {oob_mem_wen, oob_write_addr}, {1'b1, 16'h0});
        run_phase(64'h3F, 16'hAB10, 16'h0001, k);
        chk("ovf_cap_count", cap_count, 4);
        chk("ovf_flag", cap_overflow, 1);
        rd_check(2'd0, 8'h10);
        rd_check(2'd1, 8'h11);
        rd_check(2'd2, 8'h12);
        rd_check(2'd3, 8'h13);

        // Abort on the second load handshake.
        start_pulse();
        chk("abort_restart_clear", {cap_count, cap_overflow}, 0);
        ld_valid = 1'b1; ld_data = 16'hAAAA;
        @(negedge clk);
        chk("abort_w0", {oob_mem_wen, oob_write_addr, oob_write_data}, {1'b1, 16'h0, 16'hAAAA});
        ld_data = 16'hBBBB; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; ld_valid = 1'b0;
        chk("abort_w1", {oob_mem_wen, oob_write_addr, oob_write_data}, {1'b1, 16'h1, 16'hBBBB});
        chk("abort_state", {done, busy, comp_rst, ld_ready}, 4'b1010);
        @(negedge clk);
        chk("abort_wen_off", {oob_mem_wen, done}, 2'b01);
        start_pulse();
        chk("abort_restart", {cap_count, ld_ready}, 4'b0001);
        ld_valid = 1'b1; ld_data = 16'hCCCC; ld_last = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("abort_restart_addr0", {oob_mem_wen, oob_write_addr, oob_write_data}, {1'b1, 16'h0, 16'hCCCC});

        // Synchronous reset during RUN.
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!comp_rst) begin
                seen = 1;
                break;
            end
        end
        chk("reach_run", seen, 1);
        outen = 1'b1; out_w = 16'h0055;
        repeat (3) @(negedge clk);
        chk("pre_rst_cap", cap_count, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_state", {comp_rst, busy, done, ld_ready, oob_mem_wen}, 5'b10000);
        chk("midrun_rst_cap", {cap_count, rd_data}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_no_capture", cap_count, 0);
        chk("post_rst_idle", {busy, done, comp_rst}, 3'b001);
        outen = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
